// File: rtl/addsub_pkg.sv
// Shared types and helpers for the add/subtract accumulator block.
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ACC_ADD = 2'b10,
        OP_ACC_SUB = 2'b11
    } op_t;

    // Largest positive two's-complement value of the given width, as a bit pattern.
    function automatic logic [31:0] sat_max(int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    // Most negative two's-complement value of the given width, as a bit pattern.
    function automatic logic [31:0] sat_min(int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/addsub_accum_if.sv
// Handshake and data bundle between a stimulus source and the accumulator.
interface addsub_accum_if #(
    parameter int unsigned WIDTH = 6
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   inA;
    logic [WIDTH-1:0]   inB;
    addsub_pkg::op_t    op;
    logic               sat_en;
    logic               acc_clr;
    logic               sticky_clr;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   sum;
    logic               OF_S;
    logic               carry;
    logic               of_sticky;

    modport master (
        output in_valid, inA, inB, op, sat_en, acc_clr, sticky_clr, out_ready,
        input  in_ready, out_valid, sum, OF_S, carry, of_sticky
    );

    modport slave (
        input  in_valid, inA, inB, op, sat_en, acc_clr, sticky_clr, out_ready,
        output in_ready, out_valid, sum, OF_S, carry, of_sticky
    );

endinterface

// File: rtl/addsub_core.sv
// Combinational signed add/subtract with overflow detection and optional saturation.
module addsub_core
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 6
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    input  logic             sat_en,
    output logic [WIDTH-1:0] r,
    output logic             of_s,
    output logic             carry
);

    localparam logic [WIDTH-1:0] SatMax = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SatMin = WIDTH'(sat_min(WIDTH));

    logic [WIDTH-1:0] y_eff;
    logic [WIDTH:0]   raw;

    // Subtraction is x + ~y + 1; overflow uses the sign of ~y, which also
    // catches x - (-2^(WIDTH-1)) correctly.
    always_comb begin
        y_eff = sub ? ~y : y;
        raw   = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
        of_s  = (x[WIDTH-1] == y_eff[WIDTH-1]) && (raw[WIDTH-1] != x[WIDTH-1]);
        // Carry-out for add, inverted into a borrow for subtract.
        carry = raw[WIDTH] ^ sub;
        r     = raw[WIDTH-1:0];
        if (sat_en && of_s) begin
            // Overflow direction follows the sign of x (both operands share it).
            r = x[WIDTH-1] ? SatMin : SatMax;
        end
    end

endmodule

// File: rtl/addsub_accum.sv
// Registered add/subtract/accumulate stage with valid/ready on both sides.
module addsub_accum
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH       = 6,
    parameter bit          SAT_DEFAULT = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    addsub_accum_if.slave  bus
);

    // Documents the tie-off value of sat_en for integrators; no logic depends on it.
    logic unused_sat_default;
    assign unused_sat_default = SAT_DEFAULT;

    logic             accept;
    logic             consume;
    logic             is_acc;
    logic             sub;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] r;
    logic             of_s;
    logic             carry;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             of_q, of_d;
    logic             carry_q, carry_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign consume      = out_valid_q && bus.out_ready;

    // Operand selection: ACC ops use the accumulator (or 0 when clearing) as x and inA as y.
    always_comb begin
        is_acc = (bus.op == OP_ACC_ADD) || (bus.op == OP_ACC_SUB);
        sub    = (bus.op == OP_SUB) || (bus.op == OP_ACC_SUB);
        if (is_acc) begin
            x = bus.acc_clr ? '0 : acc_q;
            y = bus.inA;
        end else begin
            x = bus.inA;
            y = bus.inB;
        end
    end

    addsub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .x      (x),
        .y      (y),
        .sub    (sub),
        .sat_en (bus.sat_en),
        .r      (r),
        .of_s   (of_s),
        .carry  (carry)
    );

    // Next-state for the output register, accumulator and sticky flag.
    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        of_d        = of_q;
        carry_d     = carry_q;
        sticky_d    = sticky_q;
        acc_d       = acc_q;

        if (accept) begin
            out_valid_d = 1'b1;
            sum_d       = r;
            of_d        = of_s;
            carry_d     = carry;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end

        // An accepted ACC op already used 0 as its base when acc_clr is high.
        if (accept && is_acc) begin
            acc_d = r;
        end else if (bus.acc_clr) begin
            acc_d = '0;
        end

        // Set wins over clear on the same edge.
        if (accept && of_s) begin
            sticky_d = 1'b1;
        end else if (bus.sticky_clr) begin
            sticky_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            of_q        <= 1'b0;
            carry_q     <= 1'b0;
            sticky_q    <= 1'b0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            of_q        <= of_d;
            carry_q     <= carry_d;
            sticky_q    <= sticky_d;
            acc_q       <= acc_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.OF_S      = of_q;
    assign bus.carry     = carry_q;
    assign bus.of_sticky = sticky_q;

endmodule

// File: tb/tb_addsub_accum.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops on each consumed output.
module tb_addsub_accum;
    import addsub_pkg::*;

    localparam int W = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addsub_accum_if #(.WIDTH(W)) intf ();

    addsub_accum #(
        .WIDTH       (W),
        .SAT_DEFAULT (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf.slave)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         of_s;
        logic         carry;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   m_acc = 0;
    bit   m_sticky = 1'b0;

    logic rand_ready = 1'b0;
    logic force_ready = 1'b1;
    logic rnd_ready = 1'b1;
    assign intf.out_ready = rand_ready ? rnd_ready : force_ready;

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    function automatic void check(string name, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // Reference: exact integer arithmetic, then range test, wrap or clamp.
    function automatic void model_accept(logic [W-1:0] a, logic [W-1:0] b, op_t op,
                                         logic sat, logic clr);
        int   max_v = (1 << (W - 1)) - 1;
        int   min_v = -(1 << (W - 1));
        int   modv  = 1 << W;
        int   x, y, exact, ux, uy, res;
        bit   is_acc, sub, of, cy;
        exp_t e;
        is_acc = (op == OP_ACC_ADD) || (op == OP_ACC_SUB);
        sub    = (op == OP_SUB) || (op == OP_ACC_SUB);
        x      = is_acc ? (clr ? 0 : m_acc) : int'($signed(a));
        y      = is_acc ? int'($signed(a)) : int'($signed(b));
        exact  = sub ? x - y : x + y;
        of     = (exact > max_v) || (exact < min_v);
        ux     = (x + modv) % modv;
        uy     = (y + modv) % modv;
        cy     = sub ? (ux < uy) : (ux + uy >= modv);
        if (sat && of) begin
            res = (exact > max_v) ? max_v : min_v;
        end else begin
            res = ((exact % modv) + modv) % modv;
            if (res > max_v) res -= modv;
        end
        e.sum   = res[W-1:0];
        e.of_s  = of;
        e.carry = cy;
        sb.push_back(e);
        if (is_acc) m_acc = res;
        else if (clr) m_acc = 0;
        if (of) m_sticky = 1'b1;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input op_t op,
                         input logic sat, input logic clr);
        int n = 0;
        bit done = 1'b0;
        intf.in_valid = 1'b1;
        intf.inA      = a;
        intf.inB      = b;
        intf.op       = op;
        intf.sat_en   = sat;
        intf.acc_clr  = clr;
        while (!done) begin
            @(negedge clk);
            if (intf.in_ready) begin
                model_accept(a, b, op, sat, clr);
                done = 1'b1;
            end else if (clr) begin
                m_acc = 0;
            end
            @(posedge clk);
            #1;
            intf.acc_clr = 1'b0;
            clr = 1'b0;
            n++;
            if (!done && n > 50) begin
                check("accept_timeout", 0, 1);
                done = 1'b1;
            end
        end
        intf.in_valid = 1'b0;
        intf.acc_clr  = 1'b0;
    endtask

    // Monitor: every consumed output is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && intf.out_valid && intf.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum", int'(intf.sum), int'(e.sum));
                check("OF_S", int'(intf.OF_S), int'(e.of_s));
                check("carry", int'(intf.carry), int'(e.carry));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        intf.in_valid   = 1'b0;
        intf.inA        = '0;
        intf.inB        = '0;
        intf.op         = OP_ADD;
        intf.sat_en     = 1'b0;
        intf.acc_clr    = 1'b0;
        intf.sticky_clr = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(intf.out_valid), 0);
        check("rst_sum", int'(intf.sum), 0);
        check("rst_sticky", int'(intf.of_sticky), 0);
        check("rst_in_ready", int'(intf.in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: plain adds, one-cycle latency
        issue(6'd15, 6'd8, OP_ADD, 1'b0, 1'b0);
        check("latency_valid", int'(intf.out_valid), 1);
        issue(6'd1, 6'd9, OP_ADD, 1'b0, 1'b0);

        // 2: positive overflow, wrap then saturate; sticky set and clear
        issue(6'd31, 6'd1, OP_ADD, 1'b0, 1'b0);
        check("sticky_set", int'(intf.of_sticky), 1);
        issue(6'd31, 6'd1, OP_ADD, 1'b1, 1'b0);
        intf.sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        intf.sticky_clr = 1'b0;
        m_sticky = 1'b0;
        check("sticky_clr", int'(intf.of_sticky), 0);

        // 3: subtraction borrow and negative saturation
        issue(6'd0, 6'd1, OP_SUB, 1'b0, 1'b0);
        issue(6'd32, 6'd1, OP_SUB, 1'b1, 1'b0);

        // 4: accumulate 10 four times, wrapping then saturating; ACC_ADD 0 reads back acc
        issue(6'd10, 6'd0, OP_ACC_ADD, 1'b0, 1'b1);
        repeat (3) issue(6'd10, 6'd0, OP_ACC_ADD, 1'b0, 1'b0);
        issue(6'd10, 6'd0, OP_ACC_ADD, 1'b1, 1'b1);
        repeat (3) issue(6'd10, 6'd0, OP_ACC_ADD, 1'b1, 1'b0);
        issue(6'd0, 6'd0, OP_ACC_ADD, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // 5: backpressure holds the result and blocks a second op
        force_ready = 1'b0;
        issue(6'd5, 6'd6, OP_ADD, 1'b0, 1'b0);
        check("bp_in_ready", int'(intf.in_ready), 0);
        intf.in_valid = 1'b1;
        intf.inA      = 6'd7;
        intf.inB      = 6'd1;
        intf.op       = OP_ADD;
        intf.sat_en   = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_ready", int'(intf.in_ready), 0);
            check("bp_hold_valid", int'(intf.out_valid), 1);
            check("bp_hold_sum", int'(intf.sum), 11);
            @(posedge clk);
            #1;
        end
        force_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", int'(intf.in_ready), 1);
        if (intf.in_ready) model_accept(6'd7, 6'd1, OP_ADD, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        intf.in_valid = 1'b0;
        check("bp_valid_stays", int'(intf.out_valid), 1);
        check("bp_new_sum", int'(intf.sum), 8);

        // 6: reset while a result is held with acc=20
        issue(6'd10, 6'd0, OP_ACC_ADD, 1'b0, 1'b1);
        issue(6'd10, 6'd0, OP_ACC_ADD, 1'b0, 1'b0);
        force_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        m_acc = 0;
        m_sticky = 1'b0;
        check("rst2_out_valid", int'(intf.out_valid), 0);
        check("rst2_sum", int'(intf.sum), 0);
        check("rst2_sticky", int'(intf.of_sticky), 0);
        force_ready = 1'b1;
        issue(6'd5, 6'd0, OP_ACC_ADD, 1'b0, 1'b0);

        // Randomized traffic with random consumer backpressure
        rand_ready = 1'b1;
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            issue(W'($urandom), W'($urandom), op_t'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end
        rand_ready = 1'b0;
        force_ready = 1'b1;

        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", sb.size(), 0);
        check("sticky_final", int'(intf.of_sticky), int'(m_sticky));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
